// File: rtl/rf_wb_ctrl_if.sv
// Write-back bus: EXU and LSU result sources, regfile write port and forwarding view.
// The write-back controller uses the slave modport; result sources use master.
interface rf_wb_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            exu_wb_valid;
  logic            exu_wb_ready;
  logic [4:0]      exu_wb_rd;
  logic [XLEN-1:0] exu_wb_data;

  logic            lsu_wb_valid;
  logic            lsu_wb_ready;
  logic [4:0]      lsu_wb_rd;
  logic [XLEN-1:0] lsu_wb_data;
  logic [1:0]      lsu_wb_size;
  logic            lsu_wb_unsigned;

  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;

  modport master (
    output exu_wb_valid, exu_wb_rd, exu_wb_data,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data, lsu_wb_size, lsu_wb_unsigned,
    input  exu_wb_ready, lsu_wb_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  exu_wb_valid, exu_wb_rd, exu_wb_data,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data, lsu_wb_size, lsu_wb_unsigned,
    output exu_wb_ready, lsu_wb_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/rf_wb_ctrl.sv
// Regfile write-back controller: arbitrates EXU results against LSU load returns,
// extends load data and registers one regfile write per cycle.
module rf_wb_ctrl #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic         core_clk,
  input  logic         core_rst_n,
  rf_wb_ctrl_if.slave  bus
);

  typedef enum logic {StNormal, StBoost} state_e;

  state_e          state_q;
  logic [3:0]      wait_cnt_q;

  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            exu_ready, lsu_ready;
  logic            exu_hs, lsu_hs;
  logic            load_sgn;
  logic [XLEN-1:0] load_ext;

  // Readies are gated by reset so neither source can handshake while held in reset.
  always_comb begin
    exu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (core_rst_n) begin
      if (state_q == StBoost) begin
        exu_ready = bus.exu_wb_valid;
        lsu_ready = bus.lsu_wb_valid & ~bus.exu_wb_valid;
      end else begin
        lsu_ready = bus.lsu_wb_valid;
        exu_ready = bus.exu_wb_valid & ~bus.lsu_wb_valid;
      end
    end
  end

  assign exu_hs = bus.exu_wb_valid & exu_ready;
  assign lsu_hs = bus.lsu_wb_valid & lsu_ready;

  assign bus.exu_wb_ready = exu_ready;
  assign bus.lsu_wb_ready = lsu_ready;

  assign load_sgn = ~bus.lsu_wb_unsigned;

  always_comb begin
    case (bus.lsu_wb_size)
      2'b00:   load_ext = {{(XLEN-8){load_sgn & bus.lsu_wb_data[7]}},   bus.lsu_wb_data[7:0]};
      2'b01:   load_ext = {{(XLEN-16){load_sgn & bus.lsu_wb_data[15]}}, bus.lsu_wb_data[15:0]};
      2'b10:   load_ext = {{(XLEN-32){load_sgn & bus.lsu_wb_data[31]}}, bus.lsu_wb_data[31:0]};
      default: load_ext = bus.lsu_wb_data;
    endcase
  end

  // x0 writes still consume the handshake and update the address/data view, but never strobe.
  always_comb begin
    rf_wen_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (exu_hs) begin
      rf_wen_d = (bus.exu_wb_rd != 5'd0);
      waddr_d  = bus.exu_wb_rd;
      wdata_d  = bus.exu_wb_data;
    end else if (lsu_hs) begin
      rf_wen_d = (bus.lsu_wb_rd != 5'd0);
      waddr_d  = bus.lsu_wb_rd;
      wdata_d  = load_ext;
    end
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rf_wen_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rf_wen_q <= rf_wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Starvation guard: after MAX_WAIT consecutive denials EXU gets priority for one win.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q    <= StNormal;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StNormal: begin
          if (bus.exu_wb_valid && !exu_ready) begin
            if (wait_cnt_q >= 4'(MAX_WAIT - 1)) begin
              state_q <= StBoost;
            end
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end else begin
            wait_cnt_q <= '0;
          end
        end
        StBoost: begin
          if (!bus.exu_wb_valid || exu_ready) begin
            state_q    <= StNormal;
            wait_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.fwd_valid = rf_wen_q & (waddr_q != 5'd0);
  assign bus.fwd_rd    = waddr_q;
  assign bus.fwd_data  = wdata_q;

  a_one_winner: assert property (@(posedge core_clk) disable iff (!core_rst_n)
    !(exu_hs && lsu_hs));

  a_boost_serves_exu: assert property (@(posedge core_clk) disable iff (!core_rst_n)
    (state_q == StBoost && bus.exu_wb_valid) |-> exu_ready);

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Randomized bench for rf_wb_ctrl with a behavioural arbitration/extension model
// plus directed scenarios pinned by literal expectations.
module tb_rf_wb_ctrl;
  localparam int XLEN     = 64;
  localparam int MAX_WAIT = 4;

  logic core_clk   = 1'b0;
  logic core_rst_n = 1'b1;

  rf_wb_ctrl_if #(.XLEN(XLEN)) bus ();

  rf_wb_ctrl #(
    .XLEN     (XLEN),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .bus        (bus)
  );

  always #5 core_clk = ~core_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last expected write, and how many cycles in a row EXU has been refused.
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  int          m_streak;

  logic act_er, act_lr;
  logic exu_hs, lsu_hs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ext(input logic [63:0] d, input logic [1:0] sz, input logic u);
    int          bits;
    logic [63:0] mask;
    logic [63:0] v;
    bits = 8 << sz;
    mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    v    = d & mask;
    if (!u && bits < 64 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_reset();
    m_wen    = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_streak = 0;
  endtask

  task automatic drive_exu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    bus.exu_wb_valid = v;
    bus.exu_wb_rd    = rd;
    bus.exu_wb_data  = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [63:0] d,
                           input logic [1:0] sz, input logic u);
    bus.lsu_wb_valid    = v;
    bus.lsu_wb_rd       = rd;
    bus.lsu_wb_data     = d;
    bus.lsu_wb_size     = sz;
    bus.lsu_wb_unsigned = u;
  endtask

  // One clock: compare everything at the negedge, then advance the model at the posedge.
  task automatic do_cycle();
    logic        ev, lv, u, er, lr;
    logic [4:0]  erd, lrd;
    logic [63:0] ed, ld;
    logic [1:0]  sz;
    @(negedge core_clk);
    ev = bus.exu_wb_valid; erd = bus.exu_wb_rd; ed = bus.exu_wb_data;
    lv = bus.lsu_wb_valid; lrd = bus.lsu_wb_rd; ld = bus.lsu_wb_data;
    sz = bus.lsu_wb_size;  u   = bus.lsu_wb_unsigned;
    if (m_streak >= MAX_WAIT) begin
      er = ev;
      lr = lv && !ev;
    end else begin
      lr = lv;
      er = ev && !lv;
    end
    chk("exu_ready", 64'(bus.exu_wb_ready), 64'(er));
    chk("lsu_ready", 64'(bus.lsu_wb_ready), 64'(lr));
    chk("rf_wen",    64'(bus.rf_wen),       64'(m_wen));
    chk("rf_waddr",  64'(bus.rf_waddr),     64'(m_addr));
    chk("rf_wdata",  bus.rf_wdata,          m_data);
    chk("fwd_valid", 64'(bus.fwd_valid),    64'(m_wen && m_addr != 5'd0));
    chk("fwd_rd",    64'(bus.fwd_rd),       64'(m_addr));
    chk("fwd_data",  bus.fwd_data,          m_data);
    act_er = bus.exu_wb_ready;
    act_lr = bus.lsu_wb_ready;
    exu_hs = er;
    lsu_hs = lr;
    @(posedge core_clk);
    if (er) begin
      m_wen = (erd != 5'd0); m_addr = erd; m_data = ed;
    end else if (lr) begin
      m_wen = (lrd != 5'd0); m_addr = lrd; m_data = ext(ld, sz, u);
    end else begin
      m_wen = 1'b0;
    end
    m_streak = (ev && !er) ? m_streak + 1 : 0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_exu(1'b0, 5'd0, 64'd0);
    drive_lsu(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
    model_reset();
    exu_hs = 1'b0;
    lsu_hs = 1'b0;
    #1 core_rst_n = 1'b0;
    #1;
    drive_exu(1'b1, 5'd1, 64'h11);
    drive_lsu(1'b1, 5'd2, 64'h22, 2'd3, 1'b0);
    #1;
    chk("rst_exu_ready", 64'(bus.exu_wb_ready), 64'd0);
    chk("rst_lsu_ready", 64'(bus.lsu_wb_ready), 64'd0);
    chk("rst_rf_wen",    64'(bus.rf_wen),       64'd0);
    chk("rst_waddr",     64'(bus.rf_waddr),     64'd0);
    chk("rst_wdata",     bus.rf_wdata,          64'd0);
    drive_exu(1'b0, 5'd0, 64'd0);
    drive_lsu(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
    #9 core_rst_n = 1'b1;
    @(posedge core_clk);
    #1;

    // EXU only
    drive_exu(1'b1, 5'd5, 64'h1234);
    do_cycle();
    chk("t2_exu_ready", 64'(act_er), 64'd1);
    chk("t2_wen",       64'(bus.rf_wen),    64'd1);
    chk("t2_waddr",     64'(bus.rf_waddr),  64'd5);
    chk("t2_wdata",     bus.rf_wdata,       64'h1234);
    chk("t2_fwd_valid", 64'(bus.fwd_valid), 64'd1);
    drive_exu(1'b0, 5'd0, 64'd0);

    // Load extension
    drive_lsu(1'b1, 5'd7, 64'h1234_5678_9ABC_DE80, 2'b00, 1'b0);
    do_cycle();
    chk("t3_sext_byte", bus.rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    drive_lsu(1'b1, 5'd8, 64'h0000_0000_FFFF_8001, 2'b01, 1'b1);
    do_cycle();
    chk("t3_zext_half", bus.rf_wdata, 64'h0000_0000_0000_8001);
    drive_lsu(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
    do_cycle();

    // Conflict in NORMAL: LSU first, EXU next
    drive_exu(1'b1, 5'd3, 64'hAAAA);
    drive_lsu(1'b1, 5'd4, 64'h55, 2'b11, 1'b0);
    do_cycle();
    chk("t4_lsu_ready", 64'(act_lr), 64'd1);
    chk("t4_exu_ready", 64'(act_er), 64'd0);
    chk("t4_lsu_waddr", 64'(bus.rf_waddr), 64'd4);
    drive_lsu(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
    do_cycle();
    chk("t4_exu_ready2", 64'(act_er), 64'd1);
    chk("t4_exu_waddr",  64'(bus.rf_waddr), 64'd3);
    chk("t4_exu_wdata",  bus.rf_wdata, 64'hAAAA);
    drive_exu(1'b0, 5'd0, 64'd0);
    do_cycle();

    // Starvation: EXU refused MAX_WAIT times, wins the next cycle
    drive_exu(1'b1, 5'd9, 64'h5A5A);
    for (int k = 0; k <= MAX_WAIT; k++) begin
      if (k < MAX_WAIT) drive_lsu(1'b1, 5'(10 + k), 64'(k), 2'b11, 1'b0);
      do_cycle();
      chk("t5_exu_ready", 64'(act_er), 64'(k == MAX_WAIT));
      chk("t5_lsu_ready", 64'(act_lr), 64'(k != MAX_WAIT));
    end
    chk("t5_boost_waddr", 64'(bus.rf_waddr), 64'd9);
    drive_exu(1'b1, 5'd11, 64'h77);
    do_cycle();
    chk("t5_normal_lsu", 64'(act_lr), 64'd1);
    chk("t5_normal_exu", 64'(act_er), 64'd0);
    drive_lsu(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
    do_cycle();
    drive_exu(1'b0, 5'd0, 64'd0);
    do_cycle();

    // x0 destination
    drive_exu(1'b1, 5'd0, 64'hDEAD);
    do_cycle();
    chk("t6_ready",     64'(act_er), 64'd1);
    chk("t6_wen",       64'(bus.rf_wen), 64'd0);
    chk("t6_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    drive_exu(1'b0, 5'd0, 64'd0);
    do_cycle();

    // Reset with a write in flight and another just offered
    drive_exu(1'b1, 5'd12, 64'hBEEF);
    do_cycle();
    chk("t1_pending_wen", 64'(bus.rf_wen), 64'd1);
    drive_exu(1'b1, 5'd13, 64'hCAFE);
    drive_lsu(1'b1, 5'd14, 64'hF00D, 2'b11, 1'b1);
    #2 core_rst_n = 1'b0;
    #1;
    chk("t1_async_wen",   64'(bus.rf_wen),       64'd0);
    chk("t1_async_waddr", 64'(bus.rf_waddr),     64'd0);
    chk("t1_async_wdata", bus.rf_wdata,          64'd0);
    chk("t1_async_fwd",   64'(bus.fwd_valid),    64'd0);
    chk("t1_async_eready", 64'(bus.exu_wb_ready), 64'd0);
    chk("t1_async_lready", 64'(bus.lsu_wb_ready), 64'd0);
    @(posedge core_clk);
    #1;
    chk("t1_no_write", 64'(bus.rf_wen), 64'd0);
    drive_exu(1'b0, 5'd0, 64'd0);
    drive_lsu(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
    #2 core_rst_n = 1'b1;
    model_reset();
    exu_hs = 1'b0;
    lsu_hs = 1'b0;

    // Random traffic; second half loads LSU heavily to provoke starvation
    for (int i = 0; i < 3000; i++) begin
      int p_lsu;
      p_lsu = (i < 1500) ? 50 : 90;
      if (!bus.exu_wb_valid || exu_hs) begin
        if ($urandom_range(0, 99) < 60)
          drive_exu(1'b1, 5'($urandom_range(0, 31)), {$urandom(), $urandom()});
        else
          drive_exu(1'b0, 5'd0, 64'd0);
      end
      if (!bus.lsu_wb_valid || lsu_hs) begin
        if ($urandom_range(0, 99) < p_lsu)
          drive_lsu(1'b1, 5'($urandom_range(0, 31)), {$urandom(), $urandom()},
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        else
          drive_lsu(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
      end
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
